dmem_ctrl: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Byte-enabled word RAM behind a req/gnt/rvalid handshake, with configurable read latency (1 or 2), a base-address window and fault reporting for misaligned, out-of-range or illegal accesses.
- Sits between the MEM stage / load-store unit and on-chip data RAM.
- Replaces the combinational read path with a registered one, so it is synthesisable as block RAM.

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/dmem_ram_bank.sv | 31 +++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - rw_type (funct3) encodings for loads and stores
//   - controller FSM state encoding
//   - byte_mask    : byte write-enable for a store of a given type/lane
//   - store_lanes  : replicate right-aligned store data across all lanes
//   - load_extend  : lane select plus sign/zero extension of a loaded word
package dmem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] rw_type, input logic [1:0] a);
    case (rw_type)
      RW_B, RW_BU: byte_mask = 4'b0001 << a;
      RW_H, RW_HU: byte_mask = 4'b0011 << {a[1], 1'b0};
      RW_W:        byte_mask = 4'b1111;
      default:     byte_mask = 4'b0000;
    endcase
  endfunction

  // Replicating the data lets the byte mask alone pick which lanes land.
  function automatic logic [31:0] store_lanes(input logic [2:0] rw_type, input logic [31:0] data);
    case (rw_type)
      RW_B, RW_BU: store_lanes = {4{data[7:0]}};
      RW_H, RW_HU: store_lanes = {2{data[15:0]}};
      default:     store_lanes = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] rw_type,
                                              input logic [1:0] a);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = word[{a, 3'b000} +: 8];
    lane_h = word[{a[1], 4'b0000} +: 16];
    case (rw_type)
      RW_B:    load_extend = {{24{lane_b[7]}}, lane_b};
      RW_BU:   load_extend = {24'h0, lane_b};
      RW_H:    load_extend = {{16{lane_h[15]}}, lane_h};
      RW_HU:   load_extend = {16'h0, lane_h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank: DEPTH_WORDS x 32 synchronous single-port RAM.
// Ports:
//   clk    rising-edge clock
//   rd_en  registered read enable; rdata updates on the next edge
//   wr_be  per-byte write enable (bit i writes wdata[8i+7:8i])
//   addr   word index
//   wdata  write data
//   rdata  registered read data
// Contents are never reset so the array maps onto block RAM.
module dmem_ram_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-enabled data-memory controller with a req/gnt/rvalid
// handshake, a base-address window and fault reporting.
// Ports:
//   clk        rising-edge clock
//   rst_n_i    asynchronous active-low reset
//   req_i      request valid
//   we_i       1 = store, 0 = load
//   addr_i     byte address
//   wdata_i    right-aligned store data
//   rw_type_i  funct3 access type (B/H/W/BU/HU)
//   gnt_o      request accepted when req_i && gnt_o
//   rvalid_o   one-cycle response pulse, RD_LATENCY cycles after accept
//   rdata_o    extended load data; 0 for stores, faults and idle cycles
//   err_o      fault flag, qualified by rvalid_o
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  rw_type_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SIZE_BYTES = 33'(DEPTH_WORDS) << 2;

  state_t state, state_nxt;
  logic   accept;

  assign accept = req_i && gnt_o;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state. With single-cycle latency the controller never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && RD_LATENCY == 2) state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    gnt_o = (state == IDLE);
  end

  // ---- stage p0: decode and fault checks on the request inputs ----
  logic [31:0]   off_p0;
  logic          range_err_p0, align_err_p0, type_err_p0, fault_p0;
  logic [AW-1:0] idx_p0;
  logic [3:0]    be_p0;
  logic          rd_en_p0;

  assign off_p0       = addr_i - BASE_ADDR;
  // Unsigned compare also catches addresses below BASE_ADDR (they wrap high).
  assign range_err_p0 = {1'b0, off_p0} >= SIZE_BYTES;
  assign align_err_p0 = ((rw_type_i == RW_H || rw_type_i == RW_HU) && addr_i[0]) ||
                        (rw_type_i == RW_W && addr_i[1:0] != 2'b00);
  assign type_err_p0  = (rw_type_i == 3'b011) || (rw_type_i == 3'b110) || (rw_type_i == 3'b111) ||
                        (we_i && (rw_type_i == RW_BU || rw_type_i == RW_HU));
  assign fault_p0     = range_err_p0 || align_err_p0 || type_err_p0;
  assign idx_p0       = off_p0[AW+1:2];
  assign be_p0        = (accept && we_i && !fault_p0) ? byte_mask(rw_type_i, addr_i[1:0]) : 4'h0;
  assign rd_en_p0     = accept && !we_i && !fault_p0;

  logic [31:0] word_p1;

  dmem_ram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .rd_en(rd_en_p0),
    .wr_be(be_p0),
    .addr (idx_p0),
    .wdata(store_lanes(rw_type_i, wdata_i)),
    .rdata(word_p1)
  );

  // ---- stage p1: RAM word registered; access type and lane travel alongside ----
  logic        vld_p1, err_p1, ld_p1;
  logic [2:0]  type_p1;
  logic [1:0]  lane_p1;
  logic [31:0] data_p1;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      ld_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      err_p1 <= accept && fault_p0;
      ld_p1  <= rd_en_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      type_p1 <= rw_type_i;
      lane_p1 <= addr_i[1:0];
    end
  end

  assign data_p1 = (vld_p1 && ld_p1) ? load_extend(word_p1, type_p1, lane_p1) : 32'h0;

  if (RD_LATENCY == 2) begin : g_lat2
    // ---- stage p2: extra output register for two-cycle latency ----
    logic        vld_p2, err_p2;
    logic [31:0] data_p2;

    always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_p2 <= 1'b0;
        err_p2 <= 1'b0;
      end else begin
        vld_p2 <= vld_p1;
        err_p2 <= err_p1;
      end
    end

    always_ff @(posedge clk) begin
      data_p2 <= data_p1;
    end

    assign rvalid_o = vld_p2;
    assign err_o    = vld_p2 && err_p2;
    assign rdata_o  = vld_p2 ? data_p2 : 32'h0;
  end else begin : g_lat1
    assign rvalid_o = vld_p1;
    assign err_o    = err_p1;
    assign rdata_o  = data_p1;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with three instances:
//   0: RD_LATENCY=1, BASE_ADDR=0,      DEPTH_WORDS=1024
//   1: RD_LATENCY=1, BASE_ADDR=0x1000, DEPTH_WORDS=16
//   2: RD_LATENCY=2, BASE_ADDR=0,      DEPTH_WORDS=1024
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n, req, we, gnt, rvalid, err;
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [2:0]  rwt    [3];
  logic [31:0] rdata  [3];

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n_i(rst_n[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rw_type_i(rwt[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  dmem_ctrl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n_i(rst_n[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rw_type_i(rwt[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  dmem_ctrl #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n_i(rst_n[2]), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .rw_type_i(rwt[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  // Single-cycle-latency transfer: present at negedge, sample gnt before the
  // accept edge and the response 1 time unit after it. Leaves req asserted.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] t, output logic g, output logic rv,
                      output logic [31:0] rd, output logic er);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; rwt[d] = t;
    #1 g = gnt[d];
    @(posedge clk);
    #1;
    rv = rvalid[d]; rd = rdata[d]; er = err[d];
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; rwt[d] = 3'b010;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt[0], rvalid[0], rdata[0], err[0]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut0 got gnt=%b rv=%b rd=%h err=%b want 1 0 0 0", gnt[0], rvalid[0], rdata[0], err[0]);
    end
    checks++;
    if ({gnt[2], rvalid[2], rdata[2], err[2]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut2 got gnt=%b rv=%b rd=%h err=%b want 1 0 0 0", gnt[2], rvalid[2], rdata[2], err[2]);
    end
    @(negedge clk);
    rst_n = 3'b111;
  endtask

  task automatic test_word_rw;
    logic g, rv, er;
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, g, rv, rd, er);
    checks++;
    if ({g, rv, er, rd} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL sw_10 got gnt=%b rv=%b err=%b rd=%h want 1 1 0 00000000", g, rv, er, rd);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({g, rv, er, rd} !== {1'b1, 1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL lw_10 got gnt=%b rv=%b err=%b rd=%h want 1 1 0 deadbeef", g, rv, er, rd);
    end
    idle(0);
  endtask

  task automatic test_byte;
    logic g, rv, er;
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h13, 32'h00000080, 3'b000, g, rv, rd, er);
    checks++;
    if ({g, rv, er, rd} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL sb_13 got gnt=%b rv=%b err=%b rd=%h want 1 1 0 00000000", g, rv, er, rd);
    end
    xfer(0, 1'b0, 32'h13, 32'h0, 3'b000, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'hFFFFFF80}) begin
      errors++;
      $display("FAIL lb_13 got rv=%b err=%b rd=%h want 1 0 ffffff80", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h13, 32'h0, 3'b100, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h00000080}) begin
      errors++;
      $display("FAIL lbu_13 got rv=%b err=%b rd=%h want 1 0 00000080", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h80ADBEEF}) begin
      errors++;
      $display("FAIL lw_10_after_sb got rv=%b err=%b rd=%h want 1 0 80adbeef", rv, er, rd);
    end
    idle(0);
  endtask

  task automatic test_half;
    logic g, rv, er;
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h20, 32'h11112222, 3'b010, g, rv, rd, er);
    xfer(0, 1'b1, 32'h22, 32'h00008001, 3'b001, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL sh_22 got rv=%b err=%b rd=%h want 1 0 00000000", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h22, 32'h0, 3'b001, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'hFFFF8001}) begin
      errors++;
      $display("FAIL lh_22 got rv=%b err=%b rd=%h want 1 0 ffff8001", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h22, 32'h0, 3'b101, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h00008001}) begin
      errors++;
      $display("FAIL lhu_22 got rv=%b err=%b rd=%h want 1 0 00008001", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h20, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h80012222}) begin
      errors++;
      $display("FAIL lw_20_after_sh got rv=%b err=%b rd=%h want 1 0 80012222", rv, er, rd);
    end
    idle(0);
  endtask

  task automatic test_faults;
    logic g, rv, er;
    logic [31:0] rd;
    xfer(0, 1'b0, 32'h11, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL lw_misaligned got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(0, 1'b1, 32'h23, 32'h0000FFFF, 3'b001, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL sh_misaligned got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b011, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL type_011 got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(0, 1'b1, 32'h10, 32'h0, 3'b100, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL store_bu got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h80ADBEEF}) begin
      errors++;
      $display("FAIL lw_10_after_faults got rv=%b err=%b rd=%h want 1 0 80adbeef", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h20, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h80012222}) begin
      errors++;
      $display("FAIL lw_20_after_faults got rv=%b err=%b rd=%h want 1 0 80012222", rv, er, rd);
    end
    // Out-of-range store at 0x1000 would alias word 0 if not blocked.
    xfer(0, 1'b1, 32'h0, 32'h55AA55AA, 3'b010, g, rv, rd, er);
    xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL sw_out_of_range got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(0, 1'b0, 32'h0, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h55AA55AA}) begin
      errors++;
      $display("FAIL lw_0_no_alias got rv=%b err=%b rd=%h want 1 0 55aa55aa", rv, er, rd);
    end
    idle(0);
  endtask

  task automatic test_idle_ignored;
    logic g, rv, er;
    logic [31:0] rd;
    @(negedge clk);
    req[0] = 1'b0; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h0; rwt[0] = 3'b010;
    @(posedge clk);
    #1;
    checks++;
    if ({rvalid[0], gnt[0]} !== 2'b01) begin
      errors++;
      $display("FAIL idle_no_resp got rv=%b gnt=%b want 0 1", rvalid[0], gnt[0]);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h80ADBEEF}) begin
      errors++;
      $display("FAIL lw_10_after_idle got rv=%b err=%b rd=%h want 1 0 80adbeef", rv, er, rd);
    end
    idle(0);
  endtask

  task automatic test_window;
    logic g, rv, er;
    logic [31:0] rd;
    xfer(1, 1'b0, 32'h0FFC, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL win_below_base got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(1, 1'b0, 32'h1040, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL win_past_end got rv=%b err=%b rd=%h want 1 1 00000000", rv, er, rd);
    end
    xfer(1, 1'b1, 32'h103C, 32'h12345678, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL win_sw_last got rv=%b err=%b rd=%h want 1 0 00000000", rv, er, rd);
    end
    xfer(1, 1'b1, 32'h1000, 32'hAAAAAAAA, 3'b010, g, rv, rd, er);
    xfer(1, 1'b1, 32'h1040, 32'hBBBBBBBB, 3'b010, g, rv, rd, er);
    xfer(1, 1'b1, 32'h0FFC, 32'hCCCCCCCC, 3'b010, g, rv, rd, er);
    xfer(1, 1'b0, 32'h103C, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++;
      $display("FAIL win_lw_last got rv=%b err=%b rd=%h want 1 0 12345678", rv, er, rd);
    end
    xfer(1, 1'b0, 32'h1000, 32'h0, 3'b010, g, rv, rd, er);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'hAAAAAAAA}) begin
      errors++;
      $display("FAIL win_lw_first got rv=%b err=%b rd=%h want 1 0 aaaaaaaa", rv, er, rd);
    end
    idle(1);
  endtask

  task automatic test_lat2_throughput;
    int pulses;
    logic exp_rv;
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D; rwt[2] = 3'b010;
    @(posedge clk);
    #1;
    checks++;
    if ({rvalid[2], gnt[2]} !== 2'b00) begin
      errors++;
      $display("FAIL lat2_sw_first_cycle got rv=%b gnt=%b want 0 0", rvalid[2], gnt[2]);
    end
    @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rvalid[2], err[2], rdata[2]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL lat2_sw_resp got rv=%b err=%b rd=%h want 1 0 00000000", rvalid[2], err[2], rdata[2]);
    end
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40; rwt[2] = 3'b010;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (gnt[2] !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL lat2_gnt_cycle%0d got %b want %b", k, gnt[2], ((k % 2) == 0));
      end
      @(posedge clk);
      #1;
      exp_rv = ((k % 2) == 1);
      if (rvalid[2] === 1'b1) pulses++;
      checks++;
      if ({rvalid[2], rdata[2]} !== {exp_rv, exp_rv ? 32'hCAFEF00D : 32'h0}) begin
        errors++;
        $display("FAIL lat2_resp_cycle%0d got rv=%b rd=%h want rv=%b", k, rvalid[2], rdata[2], exp_rv);
      end
      @(negedge clk);
    end
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    if (rvalid[2] === 1'b1) pulses++;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL lat2_pulse_count got %0d want 3", pulses);
    end
  endtask

  task automatic test_lat2_reset;
    int seen;
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40; rwt[2] = 3'b010;
    @(posedge clk);
    #1;
    checks++;
    if (gnt[2] !== 1'b0) begin
      errors++;
      $display("FAIL lat2_in_wait got gnt=%b want 0", gnt[2]);
    end
    @(negedge clk);
    req[2] = 1'b0;
    rst_n[2] = 1'b0;
    #1;
    checks++;
    if ({gnt[2], rvalid[2]} !== 2'b10) begin
      errors++;
      $display("FAIL lat2_async_reset got gnt=%b rv=%b want 1 0", gnt[2], rvalid[2]);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (rvalid[2] === 1'b1) seen++;
    end
    checks++;
    if ({seen, gnt[2]} !== {32'd0, 1'b1}) begin
      errors++;
      $display("FAIL lat2_after_reset got pulses=%0d gnt=%b want 0 1", seen, gnt[2]);
    end
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40; rwt[2] = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rvalid[2], err[2], rdata[2]} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL lat2_ram_retained got rv=%b err=%b rd=%h want 1 0 cafef00d", rvalid[2], err[2], rdata[2]);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte();
    test_half();
    test_faults();
    test_idle_ignored();
    test_window();
    test_lat2_throughput();
    test_lat2_reset();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
